// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage: latches one request, drives the
// multiplier or divider, stalls EX, and commits the 64-bit result as one HI/LO write.
module muldiv_ctrl #(
  parameter int MUL_LAT   = 1,
  parameter int DIV_LIMIT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        div_timeout
);

  localparam int CW = $clog2(DIV_LIMIT + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MUL_WAIT = 2'd1;
  localparam logic [1:0] DIV_WAIT = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]    state;
  logic [1:0]    op_q;
  logic [31:0]   src1_q, src2_q;
  logic [CW-1:0] cnt;
  logic [63:0]   result_q;
  logic          launch, div_to;

  assign launch = (state == IDLE) && req_valid && !flush;
  // ready in the last allowed cycle still wins over the watchdog
  assign div_to = (state == DIV_WAIT) && !flush && !div_ready && (cnt == CW'(DIV_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (launch) begin
          op_q   <= req_op;
          src1_q <= req_src1;
          src2_q <= req_src2;
          if (req_op[1]) begin
            state <= DIV_WAIT;
            cnt   <= '0;
          end else begin
            state <= MUL_WAIT;
            cnt   <= CW'(MUL_LAT);
          end
        end
        MUL_WAIT:
          if (flush) state <= IDLE;
          else if (cnt == '0) begin
            result_q <= mul_result;
            state    <= DONE;
          end else cnt <= cnt - CW'(1);
        DIV_WAIT:
          if (flush) state <= IDLE;
          else if (div_ready) begin
            result_q <= div_result;
            state    <= DONE;
          end else if (div_to) state <= IDLE;
          else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end

  // all outputs held at 0 while rst is high so a mid-op reset leaves no stray pulse
  always_comb begin
    stallreq    = 1'b0;
    busy        = 1'b0;
    mul_signed  = 1'b0;
    mul_ina     = '0;
    mul_inb     = '0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_op1     = '0;
    div_op2     = '0;
    div_annul   = 1'b0;
    div_timeout = 1'b0;
    hilo_we     = 1'b0;
    hi_wdata    = '0;
    lo_wdata    = '0;
    if (!rst) begin
      case (state)
        IDLE: stallreq = req_valid && !flush;
        MUL_WAIT: begin
          stallreq   = !flush;
          busy       = 1'b1;
          mul_signed = !op_q[0];
          mul_ina    = src1_q;
          mul_inb    = src2_q;
        end
        DIV_WAIT: begin
          stallreq    = !flush;
          busy        = 1'b1;
          div_start   = !div_ready;
          div_signed  = !op_q[0];
          div_op1     = src1_q;
          div_op2     = src2_q;
          div_annul   = flush || div_to;
          div_timeout = div_to;
        end
        default: begin
          busy    = 1'b1;
          hilo_we = !flush;
          if (!flush) begin
            hi_wdata = result_q[63:32];
            lo_wdata = result_q[31:0];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural multiplier/divider models, a vector table of
// corner cases, hand-written reset/flush sequences and randomized operations.
module tb_muldiv_ctrl;
  localparam int MUL_LAT   = 1;
  localparam int DIV_LIMIT = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        flush;
  logic        stallreq, busy, mul_signed, div_start, div_signed, div_annul;
  logic [31:0] mul_ina, mul_inb, div_op1, div_op2, hi_wdata, lo_wdata;
  logic [63:0] mul_result, div_result;
  logic        div_ready, hilo_we, div_timeout;

  int checks = 0;
  int errors = 0;
  int div_dly = 0;
  int dcnt;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LIMIT(DIV_LIMIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .stallreq(stallreq), .busy(busy), .mul_signed(mul_signed),
    .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_op1(div_op1),
    .div_op2(div_op2), .div_annul(div_annul), .div_result(div_result),
    .div_ready(div_ready), .hilo_we(hilo_we), .hi_wdata(hi_wdata),
    .lo_wdata(lo_wdata), .div_timeout(div_timeout)
  );

  function automatic logic [63:0] mref(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] x, y;
    x = s ? {{32{a[31]}}, a} : {32'b0, a};
    y = s ? {{32{b[31]}}, b} : {32'b0, b};
    return x * y;
  endfunction

  // {remainder, quotient}; a zero divisor returns {dividend, all ones}
  function automatic logic [63:0] dref(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y, q, r;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    x = s ? longint'($signed(a)) : longint'({32'b0, a});
    y = s ? longint'($signed(b)) : longint'({32'b0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // multiplier: MUL_LAT-deep pipeline
  logic [63:0] mp [MUL_LAT];
  always @(posedge clk) begin
    mp[0] <= mref(mul_ina, mul_inb, mul_signed);
    for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_result = mp[MUL_LAT-1];

  // divider: ready div_dly cycles after start rises; div_dly==0 never answers
  always @(posedge clk) begin
    if (rst || div_annul || !div_start) dcnt <= 0;
    else dcnt <= dcnt + 1;
  end
  assign div_ready  = (div_dly > 0) && (dcnt == div_dly);
  assign div_result = dref(div_op1, div_op2, div_signed);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      flush     = 1'b0;
      #2;
      chk("idle_busy", busy, 0);
      chk("idle_stall", stallreq, 0);
      chk("idle_we", hilo_we, 0);
      chk("idle_annul", div_annul, 0);
      @(negedge clk);
    end
  endtask

  // One instruction held by EX from launch until it retires. fk<=0 means no flush.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int dly, input int fk, input logic [31:0] ehi, input logic [31:0] elo);
    int to_k, done_k, end_k;
    logic is_to;
    to_k   = -1;
    done_k = -1;
    if (!op[1]) done_k = MUL_LAT + 2;
    else if (dly > 0 && dly <= DIV_LIMIT) done_k = dly + 2;
    else to_k = DIV_LIMIT + 1;
    end_k = (done_k >= 0) ? done_k : to_k;
    if (fk > 0 && fk <= end_k) end_k = fk;
    for (int k = 0; k <= end_k; k++) begin
      req_valid = 1'b1;
      req_op    = op;
      req_src1  = a;
      req_src2  = b;
      div_dly   = dly;
      flush     = (k == fk);
      #2;
      is_to = (k == to_k) && (k != fk);
      chk("stallreq", stallreq, (k < end_k) || is_to);
      chk("busy", busy, k > 0);
      chk("hilo_we", hilo_we, (k == done_k) && (k != fk));
      chk("div_annul", div_annul, op[1] && k > 0 && (((k == fk) && (k != done_k)) || is_to));
      chk("div_timeout", div_timeout, is_to);
      if (k == done_k && k != fk) begin
        chk("hi_wdata", hi_wdata, ehi);
        chk("lo_wdata", lo_wdata, elo);
      end
      if (k == 1 && !op[1]) begin
        chk("mul_ina", mul_ina, a);
        chk("mul_inb", mul_inb, b);
        chk("mul_signed", mul_signed, !op[0]);
        chk("div_op1_idle", div_op1, 0);
      end
      if (k == 1 && op[1]) begin
        chk("div_op1", div_op1, a);
        chk("div_op2", div_op2, b);
        chk("div_signed", div_signed, !op[0]);
        chk("div_start", div_start, 1);
        chk("mul_ina_idle", mul_ina, 0);
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    int          dly, fk;
    logic [31:0] hi, lo;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] rr;
    int          rd, rf;

    tbl[0]  = '{2'b00, 32'hFFFFFFFD, 32'd5,  0,  -1, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tbl[1]  = '{2'b01, 32'hFFFFFFFF, 32'd2,  0,  -1, 32'h00000001, 32'hFFFFFFFE};
    tbl[2]  = '{2'b11, 32'd7,        32'd2,  33, -1, 32'h00000001, 32'h00000003};
    tbl[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,  33, 10, 32'h0,        32'h0};
    tbl[4]  = '{2'b11, 32'd100,      32'd7,  0,  -1, 32'h0,        32'h0};
    tbl[5]  = '{2'b10, 32'hFFFFFFF9, 32'd2,  5,  -1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[6]  = '{2'b00, 32'd3,        32'd4,  0,  3,  32'h0,        32'h0};
    tbl[7]  = '{2'b11, 32'd9,        32'd0,  3,  -1, 32'h00000009, 32'hFFFFFFFF};
    tbl[8]  = '{2'b10, 32'hFFFFFF9C, 32'd7,  40, -1, 32'hFFFFFFFE, 32'hFFFFFFF2};
    tbl[9]  = '{2'b01, 32'd11,       32'd13, 0,  1,  32'h0,        32'h0};
    tbl[10] = '{2'b10, 32'd50,       32'd3,  4,  5,  32'h0,        32'h0};

    rst = 1'b1; req_valid = 1'b1; req_op = 2'b00; req_src1 = '0; req_src2 = '0; flush = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_stall", stallreq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", hilo_we, 0);
    chk("rst_mul_ina", mul_ina, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // flush while idle: no launch
    req_valid = 1'b1; req_op = 2'b10; flush = 1'b1;
    #2;
    chk("idleflush_stall", stallreq, 0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #2;
    chk("idleflush_busy", busy, 0);
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dly, tbl[i].fk, tbl[i].hi, tbl[i].lo);
    idle(2);

    // mult then divu back to back, reset in the middle of the divide
    run_op(2'b00, 32'd6, 32'd7, 0, -1, 32'd0, 32'd42);
    for (int k = 0; k < 6; k++) begin
      req_valid = 1'b1; req_op = 2'b11; req_src1 = 32'd1000; req_src2 = 32'd3;
      div_dly = 33; flush = 1'b0;
      #2;
      chk("rstseq_stall", stallreq, 1);
      @(negedge clk);
    end
    rst = 1'b1;
    #2;
    chk("rstmid_stall", stallreq, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_start", div_start, 0);
    chk("rstmid_annul", div_annul, 0);
    chk("rstmid_op1", div_op1, 0);
    chk("rstmid_we", hilo_we, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(40);
    run_op(2'b11, 32'd1000, 32'd3, 6, -1, 32'd1, 32'd333);

    for (int n = 0; n < 200; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      rd  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 36));
      rf  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : -1;
      rr  = rop[1] ? dref(ra, rb, !rop[0]) : mref(ra, rb, !rop[0]);
      run_op(rop, ra, rb, rd, rf, rr[63:32], rr[31:0]);
      if ($urandom_range(0, 1) == 0) idle(1);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller for the HI/LO multiply/divide resources used by the EX stage.
- Accepts one mult/multu/div/divu request from EX and latches the operands.
- Drives the pipelined multiplier or the iterative divider, generates the EX stall request, and handles flush and divider watchdog abort.
- Commits the 64-bit result as a single-cycle HI/LO write that feeds the HI/LO register file and the ID forwarding path.

Parameters:
MUL_LAT, 1, clock cycles from mul_ina/mul_inb/mul_signed stable to mul_result valid (1..4)
DIV_LIMIT, 40, maximum DIV_WAIT cycles without div_ready before abort (>= 34)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  EX holds a mul/div instruction
req_op  in  2  00 mult, 01 multu, 10 div, 11 divu
req_src1  in  32  rs operand (dividend / multiplicand)
req_src2  in  32  rt operand (divisor / multiplier)
flush  in  1  squash the in-flight operation
stallreq  out  1  stall request to the stall controller
busy  out  1  state != IDLE
mul_signed  out  1  signed multiply select
mul_ina  out  32  multiplier operand A
mul_inb  out  32  multiplier operand B
mul_result  in  64  {hi, lo} product
div_start  out  1  divider start (level)
div_signed  out  1  signed divide select
div_op1  out  32  dividend
div_op2  out  32  divisor
div_annul  out  1  cancel the divider
div_result  in  64  {remainder, quotient}
div_ready  in  1  divider result valid
hilo_we  out  1  HI and LO write enable (one-cycle pulse)
hi_wdata  out  32  HI write data
lo_wdata  out  32  LO write data
div_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: state=IDLE; every output is 0; operand, op, counter and result registers are cleared.
- Reset mid-operation: the controller returns to IDLE next cycle with no hilo_we and no annul pulse. The divider is reset by the same rst.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- IDLE, req_valid=1 and flush=0 at cycle t:
  - Latch op, src1 and src2.
  - stallreq=1 combinationally in cycle t.
  - Next state is MUL_WAIT (op[1]=0, cnt loaded with MUL_LAT) or DIV_WAIT (op[1]=1, cnt cleared).
- IDLE, flush=1: no launch; stallreq=0.
- Operand outputs are driven from the latched registers only while in MUL_WAIT or DIV_WAIT; they are 0 in every other state.
  - mul_signed = !op[0]; div_signed = !op[0].
- MUL_WAIT:
  - stallreq=1; cnt decrements each cycle.
  - When cnt reaches 0, mul_result is captured into the result register and the next state is DONE.
  - Mult occupancy: hilo_we asserts in cycle t+MUL_LAT+2.
- DIV_WAIT:
  - stallreq=1; div_start = !div_ready.
  - cnt increments each cycle.
  - div_ready=1: capture div_result, next state DONE.
  - cnt reaches DIV_LIMIT without div_ready: div_annul=1 and div_timeout=1 for that cycle, next state IDLE, no hilo_we.
- DONE (one cycle):
  - hilo_we=1, hi_wdata=result[63:32], lo_wdata=result[31:0]; stallreq=0 so EX advances.
  - req_valid is ignored in this cycle; the same instruction is still present and must not relaunch.
  - Next state is IDLE.
- Flush:
  - In MUL_WAIT: go to IDLE, stallreq=0 that cycle, no write.
  - In DIV_WAIT: additionally div_annul=1 that cycle.
  - In DONE: hilo_we is suppressed.
- Flush and div_ready in the same DIV_WAIT cycle: flush wins; no write, annul pulse.
- Divide by zero: no special handling; the divider output is committed as returned.
- Back-to-back requests: after DONE the controller is in IDLE, so a new request in the next cycle launches with zero bubble.
- Result arithmetic: mul_result and div_result are passed through unmodified.
  - HI holds the high product or the remainder; LO holds the low product or the quotient.

Test Plan:
- mult, src1=0xFFFFFFFD (-3), src2=5, MUL_LAT=1 -> stallreq high cycles t..t+2; hilo_we at t+3 with hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu, src1=0xFFFFFFFF, src2=2 -> hi=0x00000001, lo=0xFFFFFFFE; mul_signed=0 throughout.
- divu 7/2 with the divider model asserting ready 33 cycles after start -> div_start high until ready; hilo_we with hi=1, lo=3; stallreq drops in the same cycle.
- div -7/2 with flush at DIV_WAIT cycle 10 -> div_annul pulses exactly once; no hilo_we; stallreq=0 in the flush cycle; next req_valid launches a fresh divide.
- divider model that never asserts ready, DIV_LIMIT=40 -> div_timeout and div_annul pulse together after 40 DIV_WAIT cycles; no write; controller returns to IDLE.
- Back-to-back mult then divu, with rst asserted mid-divide -> mult commits once; after rst all outputs are 0, busy=0, and there is no spurious hilo_we.
